// File: rtl/imem_load_ctrl.sv
// Instruction-memory load sequencer: accepts a valid/ready word stream, owns the
// memory write port and stalls the core while busy. Optional feature: IMEM_LOAD_CHECKSUM_EN.
module imem_load_ctrl #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [INS_ADDRESS-3:0] base_word,
  input  logic [INS_ADDRESS-2:0] num_words,
  input  logic                   s_valid,
  input  logic [INS_W-1:0]       s_data,
  output logic                   s_ready,
  output logic                   we,
  output logic [INS_ADDRESS-3:0] wa,
  output logic [INS_W-1:0]       wd,
  output logic                   core_stall,
  output logic                   busy,
  output logic                   done,
  output logic                   err
`ifdef IMEM_LOAD_CHECKSUM_EN
  ,
  input  logic [INS_W-1:0]       exp_sum,
  output logic [INS_W-1:0]       sum
`endif
);

  localparam int IW = INS_ADDRESS - 2;
  localparam int CW = INS_ADDRESS - 1;
  localparam logic [CW-1:0] DEPTH = {1'b1, {IW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state, state_n;
  logic [IW-1:0]  idx, idx_n;
  logic [CW-1:0]  rem, rem_n;
  logic           hs;
  logic           err_set;
  logic           sum_clr;
  logic           sum_ok;

`ifdef IMEM_LOAD_CHECKSUM_EN
  assign sum_ok = (sum == exp_sum);
`else
  assign sum_ok = 1'b1;
`endif

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    rem_n   = rem;
    s_ready = 1'b0;
    hs      = 1'b0;
    done    = 1'b0;
    err_set = 1'b0;
    sum_clr = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (num_words != '0 && num_words <= DEPTH) begin
            idx_n   = base_word;
            rem_n   = num_words;
            sum_clr = 1'b1;
            state_n = S_LOAD;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_n = S_IDLE;
          err_set = 1'b1;
        end else begin
          // Withhold ready during reset so the source never sees a word taken that is discarded.
          s_ready = !reset;
          hs      = s_valid && !reset;
          if (hs) begin
            idx_n = idx + 1'b1;
            rem_n = rem - 1'b1;
            if (rem == CW'(1)) state_n = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_n = S_DONE;
        if (abort) begin
          state_n = S_IDLE;
          err_set = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        if (sum_ok) done = 1'b1;
        else        err_set = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
    if (start && state != S_IDLE) err_set = 1'b1;
  end

  assign busy       = (state != S_IDLE);
  assign core_stall = busy;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      rem   <= '0;
      we    <= 1'b0;
      wa    <= '0;
      wd    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      rem   <= rem_n;
      we    <= hs;
      if (hs) begin
        wa <= idx;
        wd <= s_data;
      end
      err <= err | err_set;
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset)        sum <= '0;
    else if (sum_clr) sum <= '0;
    else if (hs)      sum <= sum + s_data;
  end
`else
  logic unused_ok;
  assign unused_ok = sum_clr;
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed self-checking bench for imem_load_ctrl; checksum cases run when
// IMEM_LOAD_CHECKSUM_EN is defined.
module tb_imem_load_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [6:0]  base_word = '0;
  logic [7:0]  num_words = '0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, we, core_stall, busy, done, err;
  logic [6:0]  wa;
  logic [31:0] wd;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0] exp_sum = '0;
  logic [31:0] sum;
`endif

  int n_vec = 0;
  int n_err = 0;
  int n_writes = 0;
  int n_done = 0;

  imem_load_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_word(base_word), .num_words(num_words),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .we(we), .wa(wa), .wd(wd), .core_stall(core_stall),
    .busy(busy), .done(done), .err(err)
`ifdef IMEM_LOAD_CHECKSUM_EN
    , .exp_sum(exp_sum), .sum(sum)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we)   n_writes++;
    if (done) n_done++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start_load(input logic [6:0] b, input logic [7:0] n);
    base_word = b;
    num_words = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  logic [31:0] words [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00308193};
  int wc, dc;

  initial begin
    do_reset();
    check("rst_outs", {26'd0, s_ready, we, core_stall, busy, done, err}, 32'd0);
    check("rst_wa", {25'd0, wa}, 32'd0);
    check("rst_wd", wd, 32'd0);

    // Basic back-to-back load
    start_load(7'd0, 8'd4);
    check("basic_busy", {30'd0, busy, core_stall}, 32'd3);
    check("basic_ready", {31'd0, s_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      send(words[i]);
      check("basic_we", {31'd0, we}, 32'd1);
      check("basic_wa", {25'd0, wa}, i);
      check("basic_wd", wd, words[i]);
    end
    check("basic_drain_done", {31'd0, done}, 32'd0);
    check("basic_drain_ready", {31'd0, s_ready}, 32'd0);
    tick();
    check("basic_done", {30'd0, done, we}, 32'd2);
    tick();
    check("basic_idle", {29'd0, busy, core_stall, done}, 32'd0);
    check("basic_err", {31'd0, err}, 32'd0);

    // Throttled stream
    wc = n_writes;
    start_load(7'd10, 8'd3);
    send(32'hA);
    check("thr_w0", {24'd0, we, wa}, {24'd0, 1'b1, 7'd10});
    tick();
    check("thr_gap0", {24'd0, we, wa}, {24'd0, 1'b0, 7'd10});
    send(32'hB);
    check("thr_w1", {24'd0, we, wa}, {24'd0, 1'b1, 7'd11});
    tick();
    check("thr_gap1", {31'd0, we}, 32'd0);
    send(32'hC);
    check("thr_w2", {24'd0, we, wa}, {24'd0, 1'b1, 7'd12});
    check("thr_wd2", wd, 32'hC);
    tick();
    check("thr_done", {31'd0, done}, 32'd1);
    tick();
    check("thr_count", n_writes - wc, 32'd3);

    // Wrap-around
    start_load(7'd126, 8'd4);
    for (int i = 0; i < 4; i++) begin
      send(32'h100 + i);
      check("wrap_wa", {25'd0, wa}, (126 + i) % 128);
    end
    tick();
    check("wrap_done", {31'd0, done}, 32'd1);
    tick();
    check("wrap_err", {31'd0, err}, 32'd0);

    // Illegal counts
    start_load(7'd0, 8'd0);
    check("zero_err", {30'd0, err, busy}, 32'd2);
    do_reset();
    start_load(7'd0, 8'd129);
    check("big_err", {30'd0, err, busy}, 32'd2);
    do_reset();
    start_load(7'd0, 8'd128);
    check("full_ok", {30'd0, err, busy}, 32'd1);
    do_reset();

    // Start while busy
    start_load(7'd5, 8'd2);
    start = 1'b1;
    send(32'h55);
    start = 1'b0;
    check("ovl_err", {31'd0, err}, 32'd1);
    check("ovl_w0", {24'd0, we, wa}, {24'd0, 1'b1, 7'd5});
    send(32'h66);
    check("ovl_w1", {24'd0, we, wa}, {24'd0, 1'b1, 7'd6});
    tick();
    check("ovl_done", {31'd0, done}, 32'd1);
    tick();

    // Abort after two of five words
    do_reset();
    wc = n_writes;
    dc = n_done;
    start_load(7'd20, 8'd5);
    send(32'h1);
    send(32'h2);
    abort   = 1'b1;
    s_valid = 1'b1;
    #1;
    check("abort_ready", {31'd0, s_ready}, 32'd0);
    check("abort_last_we", {24'd0, we, wa}, {24'd0, 1'b1, 7'd21});
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    check("abort_idle", {30'd0, busy, we}, 32'd0);
    tick();
    tick();
    check("abort_writes", n_writes - wc, 32'd2);
    check("abort_nodone", n_done - dc, 32'd0);
    check("abort_err", {31'd0, err}, 32'd1);

    // Reset mid-load after three of eight words
    do_reset();
    start_load(7'd0, 8'd8);
    wc = n_writes;
    send(32'h11);
    send(32'h22);
    send(32'h33);
    reset   = 1'b1;
    s_valid = 1'b1;
    tick();
    check("rmid_outs", {26'd0, s_ready, we, core_stall, busy, done, err}, 32'd0);
    check("rmid_wa_wd", {25'd0, wa} | wd, 32'd0);
    reset = 1'b0;
    tick();
    tick();
    s_valid = 1'b0;
    check("rmid_quiet", {30'd0, we, busy}, 32'd0);
    check("rmid_writes", n_writes - wc, 32'd3);

`ifdef IMEM_LOAD_CHECKSUM_EN
    do_reset();
    exp_sum = 32'd6;
    start_load(7'd0, 8'd3);
    send(32'd1);
    send(32'd2);
    send(32'd3);
    check("cs_sum", sum, 32'd6);
    tick();
    check("cs_ok_done", {30'd0, done, err}, 32'd2);
    tick();
    exp_sum = 32'd7;
    start_load(7'd0, 8'd3);
    send(32'd1);
    send(32'd2);
    send(32'd3);
    tick();
    check("cs_bad_done", {31'd0, done}, 32'd0);
    tick();
    check("cs_bad_err", {31'd0, err}, 32'd1);
    check("cs_hold", sum, 32'd6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Sequences programming of the instruction memory from a valid/ready word stream before and between program runs.
- Owns the memory's write port (index, data, enable) and holds the core in stall while a load is in flight.
- Sits between the testbench/boot source and the instruction memory array; the core's read path remains untouched.

Parameters:
- INS_ADDRESS, 9: byte-address width of instruction memory; DEPTH = 2**(INS_ADDRESS-2) words (128 at default).
- INS_W, 32: instruction word width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  begin a load; sampled in IDLE only.
- abort  input  1  cancel an in-flight load.
- base_word  input  INS_ADDRESS-2  first word index written.
- num_words  input  INS_ADDRESS-1  words to load, legal 1..DEPTH.
- s_valid  input  1  stream word valid.
- s_data  input  INS_W  stream word.
- s_ready  output  1  controller accepts word this cycle.
- we  output  1  memory write enable (registered).
- wa  output  INS_ADDRESS-2  memory write word index (registered).
- wd  output  INS_W  memory write data (registered).
- core_stall  output  1  high while busy.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  sticky error flag.

Behaviour:
- Reset:
  - state = IDLE.
  - s_ready, we, core_stall, busy, done, err = 0.
  - wa = 0, wd = 0.
  - Internal index and remaining count = 0.
  - Reset mid-load discards the load; no further writes are issued.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - start=1 with num_words in 1..DEPTH: latch idx = base_word and rem = num_words, go to LOAD.
  - start=1 with num_words = 0 or num_words > DEPTH: set err, stay in IDLE.
  - start is ignored outside IDLE; start while busy sets err.
- LOAD:
  - s_ready = 1.
  - Handshake on s_valid && s_ready: next cycle we=1, wa=idx, wd=s_data. Write latency is 1 cycle from acceptance.
  - On each handshake: idx = idx+1, wrapping modulo DEPTH (e.g. 127 -> 0 at default); rem = rem-1.
  - Handshake with rem == 1: go to DRAIN.
  - s_valid low: no write, counters hold, stay in LOAD.
- DRAIN:
  - s_ready = 0.
  - The final registered write is visible this cycle (we=1).
  - Go to DONE.
- DONE:
  - done = 1 for exactly one cycle, we = 0.
  - Go to IDLE; busy and core_stall drop the following cycle.
- we is low in every cycle not immediately following a handshake.
- core_stall = busy, combinational from state.
- abort = 1 in LOAD or DRAIN:
  - Next state is IDLE, done is not asserted, err is set.
  - A write already registered from the prior cycle still completes; no new handshake is accepted in the abort cycle (s_ready forced to 0).
  - abort in IDLE or DONE has no effect.
  - abort and start together in IDLE: start is processed; abort is ignored.
- err clears only on reset.

Optional Feature:
- Macro: IMEM_LOAD_CHECKSUM_EN.
- When defined:
  - Extra ports: input exp_sum [INS_W-1:0], output sum [INS_W-1:0].
  - sum clears on entry to LOAD and accumulates s_data on each handshake, modulo 2**INS_W.
  - In DONE, if sum != exp_sum: done stays 0 and err is set; otherwise done pulses as normal.
  - sum holds its value in IDLE; it resets to 0.
- When undefined: no extra ports and no checksum logic; behaviour is exactly as above.

Test Plan:
- Basic load: base_word=0, num_words=4, words 0x00000013, 0x00100093, 0x00200113, 0x00308193 sent back-to-back -> we on 4 consecutive cycles, wa 0..3, done pulses 2 cycles after the last handshake, core_stall low the cycle after done.
- Throttled stream: s_valid toggling 1,0,1,0 for 3 words -> exactly 3 writes; no write in cycles after s_valid=0; wa increments only on handshakes.
- Wrap-around: base_word=126, num_words=4 -> wa sequence 126, 127, 0, 1; done asserted; err=0.
- Illegal and overlapping starts:
  - num_words=0 -> err=1, busy stays 0.
  - After reset, start during LOAD -> err=1, load completes normally.
- Abort: abort after 2 of 5 words -> exactly 2 writes, IDLE next cycle, done never asserted, err=1.
- Reset mid-load after 3 of 8 words -> next cycle all outputs 0, no further writes. With IMEM_LOAD_CHECKSUM_EN defined, words 1, 2, 3 with exp_sum=6 -> done=1; with exp_sum=7 -> done=0, err=1.
